// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : MIPS instruction-fetch stage. Owns the PC, keeps at most one
//                request outstanding to instruction memory and registers
//                {pc, inst, valid} as the IF/ID boundary. Honours a decode
//                stall and a branch/jump flush with redirect.
//                Optional macro IF_PERF_CNT_EN adds fetch_cnt_out, a 32-bit
//                count of instructions written valid into IF/ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
   parameter int                     PC_WIDTH   = 32,
   parameter int                     INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_in,
   input  logic                  flush_in,
   input  logic [PC_WIDTH-1:0]   redirect_pc_in,
   output logic                  imem_req_out,
   output logic [PC_WIDTH-1:0]   imem_addr_out,
   input  logic                  imem_ack_in,
   input  logic [INST_WIDTH-1:0] imem_data_in,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic [INST_WIDTH-1:0] inst_data_out,
   output logic                  inst_valid_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_cnt_out
`endif
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] c_pc_step = {{(PC_WIDTH-3){1'b0}}, 3'b100};

   state_t                r_state;
   state_t                w_state_nx;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [PC_WIDTH-1:0]   r_rdir;
   logic [PC_WIDTH-1:0]   r_buf_pc;
   logic [INST_WIDTH-1:0] r_buf_inst;
   logic [PC_WIDTH-1:0]   r_pc_out;
   logic [INST_WIDTH-1:0] r_inst;
   logic                  r_valid;

   logic [PC_WIDTH-1:0]   w_redir;
   logic [PC_WIDTH-1:0]   w_pc_nx;
   logic [PC_WIDTH-1:0]   w_rdir_nx;
   logic                  w_req;
   logic                  w_buf_ld;
   logic                  w_ifid_load;
   logic [PC_WIDTH-1:0]   w_ifid_pc;
   logic [INST_WIDTH-1:0] w_ifid_inst;
   logic                  w_ifid_kill;

   // Redirect targets are always word aligned.
   assign w_redir = {redirect_pc_in[PC_WIDTH-1:2], 2'b00};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_state_nx;
   end

   // Next-state, bus request and datapath control; flush outranks stall.
   always_comb begin
      w_state_nx  = r_state;
      w_pc_nx     = r_pc;
      w_rdir_nx   = r_rdir;
      w_req       = 1'b0;
      w_buf_ld    = 1'b0;
      w_ifid_load = 1'b0;
      w_ifid_pc   = r_pc;
      w_ifid_inst = imem_data_in;
      w_ifid_kill = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_req = 1'b1;
            if (imem_ack_in) begin
               if (flush_in) begin
                  w_pc_nx     = w_redir;
                  w_ifid_kill = 1'b1;
               end else if (stall_in) begin
                  w_buf_ld   = 1'b1;
                  w_pc_nx    = r_pc + c_pc_step;
                  w_state_nx = S_HOLD;
               end else begin
                  w_ifid_load = 1'b1;
                  w_pc_nx     = r_pc + c_pc_step;
               end
            end else if (flush_in) begin
               w_rdir_nx   = w_redir;
               w_ifid_kill = 1'b1;
               w_state_nx  = S_DRAIN;
            end else if (!stall_in) begin
               w_ifid_kill = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush_in) begin
               w_pc_nx     = w_redir;
               w_ifid_kill = 1'b1;
               w_state_nx  = S_FETCH;
            end else if (!stall_in) begin
               w_ifid_load = 1'b1;
               w_ifid_pc   = r_buf_pc;
               w_ifid_inst = r_buf_inst;
               w_state_nx  = S_FETCH;
            end
         end
         S_DRAIN: begin
            // The in-flight fetch must complete on the bus but its data is dead.
            w_req       = 1'b1;
            w_ifid_kill = 1'b1;
            if (flush_in) w_rdir_nx = w_redir;
            if (imem_ack_in) begin
               w_pc_nx    = flush_in ? w_redir : r_rdir;
               w_state_nx = S_FETCH;
            end
         end
         default: begin
            w_state_nx = S_FETCH;
         end
      endcase
   end

   // PC, redirect, skid buffer and IF/ID registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_rdir     <= '0;
         r_buf_pc   <= '0;
         r_buf_inst <= '0;
         r_pc_out   <= '0;
         r_inst     <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_pc   <= w_pc_nx;
         r_rdir <= w_rdir_nx;
         if (w_buf_ld) begin
            r_buf_pc   <= r_pc;
            r_buf_inst <= imem_data_in;
         end
         if (w_ifid_load) begin
            r_pc_out <= w_ifid_pc;
            r_inst   <= w_ifid_inst;
            r_valid  <= 1'b1;
         end else if (w_ifid_kill) begin
            r_valid  <= 1'b0;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;

   // Count every instruction written valid into IF/ID, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst)              r_fetch_cnt <= '0;
      else if (w_ifid_load) r_fetch_cnt <= r_fetch_cnt + 32'd1;
   end

   assign fetch_cnt_out = r_fetch_cnt;
`endif

   assign imem_req_out   = w_req & ~rst;
   assign imem_addr_out  = r_pc;
   assign pc_out         = r_pc_out;
   assign inst_data_out  = r_inst;
   assign inst_valid_out = r_valid;

endmodule
`default_nettype wire
